pack_i64_stream: RTL

Signed LEB128 encoder, the transmit-side counterpart of the signed LEB128 unpack path. Accepts one W-bit two's-complement integer per transaction and emits its minimal-length LEB128 byte sequence, one byte per cycle, over a valid/ready byte stream. Sits between integer producers and the byte-serial output path feeding unpack-side consumers.

---
 rtl/pack_i64_stream.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pack_i64_stream.sv
// pack_i64_stream: signed LEB128 encoder emitting one byte per cycle on a valid/ready stream.
// Optional macro PACK_I64_UNSIGNED_EN adds s_signed to pick unsigned LEB128 per sequence.
module pack_i64_stream #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_data,
`ifdef PACK_I64_UNSIGNED_EN
    input  logic         s_signed,
`endif
    input  logic         s_valid,
    output logic         s_ready,
    output logic [7:0]   m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic [3:0]   m_idx,
    output logic         busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    // Value left to encode once the low 7 bits have been emitted.
    function automatic logic [W-1:0] f_rem(input logic [W-1:0] v, input logic sgn);
        logic [W-1:0] r;
        if (sgn) begin
            r = $unsigned($signed(v) >>> 7);
        end else begin
            r = v >> 7;
        end
        return r;
    endfunction

    // A byte is final when the remainder is pure sign (or zero) extension of what was sent.
    function automatic logic f_done(input logic [W-1:0] v, input logic sgn);
        logic [W-1:0] r;
        logic         d;
        r = f_rem(v, sgn);
        if (sgn) begin
            d = ((r == {W{1'b0}}) && !v[6]) || ((r == {W{1'b1}}) && v[6]);
        end else begin
            d = (r == {W{1'b0}});
        end
        return d;
    endfunction

    logic         sgn_in_s;
`ifdef PACK_I64_UNSIGNED_EN
    assign sgn_in_s = s_signed;
`else
    assign sgn_in_s = 1'b1;
`endif

    logic [0:0]   state_q, state_d;
    logic [W-1:0] v_q, v_d;
    logic         sgn_q, sgn_d;
    logic [7:0]   m_data_q, m_data_d;
    logic         m_valid_q, m_valid_d;
    logic         m_last_q, m_last_d;
    logic [3:0]   m_idx_q, m_idx_d;

    logic         accept_s;
    logic         adv_s;
    logic [W-1:0] rem_s;
    logic         rem_done_s;
    logic         load_done_s;

    assign s_ready     = (state_q == ST_IDLE) | (m_valid_q & m_ready & m_last_q);
    assign accept_s    = s_valid & s_ready;
    assign adv_s       = m_valid_q & m_ready;
    assign rem_s       = f_rem(v_q, sgn_q);
    assign rem_done_s  = f_done(rem_s, sgn_q);
    assign load_done_s = f_done(s_data, sgn_in_s);

    // Next-state: load a new integer, step to the next byte, or fall back to idle.
    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        sgn_d     = sgn_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_idx_d   = m_idx_q;
        if (accept_s) begin
            state_d   = ST_EMIT;
            v_d       = s_data;
            sgn_d     = sgn_in_s;
            m_data_d  = {~load_done_s, s_data[6:0]};
            m_valid_d = 1'b1;
            m_last_d  = load_done_s;
            m_idx_d   = 4'd0;
        end else if (adv_s) begin
            if (!m_last_q) begin
                v_d      = rem_s;
                m_data_d = {~rem_done_s, rem_s[6:0]};
                m_last_d = rem_done_s;
                m_idx_d  = m_idx_q + 4'd1;
            end else begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            v_q       <= {W{1'b0}};
            sgn_q     <= 1'b1;
            m_data_q  <= 8'd0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_idx_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            sgn_q     <= sgn_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_idx_q   <= m_idx_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_idx   = m_idx_q;
    assign busy    = (state_q == ST_EMIT);

endmodule
